drive_sequencer: RTL and testbench
==================================

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter COUNT_CYCLES, default 100_000_000: cycles spent in COUNT before the first STRAIGHT.
REQ-002 Parameter TURN_CYCLES, default 30_000_000: minimum cycles held in LEFT/RIGHT.
REQ-003 Parameter BACK_CYCLES, default 60_000_000: minimum cycles held in BACK.
REQ-004 Parameter LOST_CYCLES, default 50_000_000: consecutive sensor==000 cycles before ERROR.
REQ-005 Parameter PLAN, default 32'h0: 16 two-bit junction actions, entry i at bits [2i+1:2i]; 0=straight, 1=left, 2=right, 3=back.
REQ-006 Parameter PLAN_LEN, default 4, legal range 1..16: number of junctions before FINISH.
REQ-007 clk  in  1  system clock, 100 MHz.
REQ-008 rst  in  1  one clock; reset is synchronous and active-high.
REQ-009 start  in  1  start button, already synchronized and debounced.
REQ-010 sensor  in  3  line sensors {left,mid,right}; 1 = line seen.
REQ-011 obstacle  in  1  distance-too-close flag, already synchronized.
REQ-012 mode  out  5  registered drive mode, encoding per REQ-014.
REQ-013 lastMode  out  5  registered previous distinct mode.

Function
REQ-014 Mode encoding: IDLE=0, START=1, COUNT=2, STRAIGHT=3, CHOOSE=4, LEFT=5, RIGHT=6, BACK=7, LITTLE_LEFT=8, LITTLE_RIGHT=9, FINISH=29, STOP=30, ERROR=31. All other codes are unreachable.
REQ-015 The start rising edge is detected internally with a registered previous value. A level held high does not retrigger.
REQ-016 IDLE: on a start rising edge go to START. Otherwise stay.
REQ-017 START: lasts exactly one cycle, then COUNT with the timer loaded.
REQ-018 COUNT: after exactly COUNT_CYCLES cycles in COUNT, go to STRAIGHT. Clear junction index and lost counter.
REQ-019 Tracking states (STRAIGHT, LITTLE_LEFT, LITTLE_RIGHT) use this sensor map:
  - 010 -> STRAIGHT
  - 110 or 100 -> LITTLE_LEFT
  - 011 or 001 -> LITTLE_RIGHT
  - 111 -> CHOOSE
  - 101 -> hold current state
  - 000 -> hold and increment lost counter
REQ-020 Lost counter clears on any sensor value other than 000. When it reaches LOST_CYCLES, go to ERROR.
REQ-021 CHOOSE: hold while sensor==111. On the first cycle with sensor!=111:
  - read PLAN[junction index] and increment the index
  - dispatch: 0->STRAIGHT, 1->LEFT, 2->RIGHT, 3->BACK
REQ-022 If the incremented index equals PLAN_LEN, go to FINISH instead of dispatching.
REQ-023 LEFT/RIGHT/BACK: load the timer with TURN_CYCLES (or BACK_CYCLES for BACK) on entry. Leave only when the timer has expired and sensor[1]==1, going to STRAIGHT.
REQ-024 Obstacle handling:
  - obstacle==1 in any of STRAIGHT, CHOOSE, LITTLE_*, LEFT, RIGHT, BACK -> STOP next cycle, saving the current state.
  - obstacle has priority over every other transition in the same cycle.
REQ-025 STOP: when obstacle==0, return to the saved state. The turn timer and lost counter freeze during STOP and resume on return.
REQ-026 FINISH and ERROR are terminal. Only a start rising edge leaves them, going to IDLE. Obstacle is ignored in both.
REQ-027 lastMode: when mode changes from value A to value B, lastMode<=A in the same cycle mode<=B. Otherwise lastMode holds.
REQ-028 Counter widths are ceil(log2(max parameter + 1)). The counters never wrap and saturate at their terminal value.

Reset
REQ-029 When rst==1 at a clk edge:
  - mode<=IDLE, lastMode<=IDLE
  - junction index, timer, lost counter, saved state and start-edge register all cleared
REQ-030 rst has priority over all inputs. Reset mid-turn or mid-STOP returns to IDLE with no residual state.

Structure
REQ-031 The mode encoding constants live in the shared package car_mode_pkg, which is also used by the motor driver.
REQ-032 One sub-module, cycle_timer:
  - load, value, enable (freeze) and expired ports
  - shared by COUNT and the turn states

Verification
REQ-033 Bench parameters for all scenarios: COUNT_CYCLES=10, TURN_CYCLES=5, BACK_CYCLES=7, LOST_CYCLES=8, PLAN_LEN=2, PLAN entries {0:left, 1:right}.
REQ-034 Bring-up: rst, then start pulse -> mode 1 for 1 cycle, 2 for 10 cycles, then 3; lastMode=2.
REQ-035 Line following: sensor 110 -> 8; then 010 -> 3 with lastMode=8; then 011 -> 9.
REQ-036 Junction sequence:
  - sensor 111 for 3 cycles -> 4; then 000 -> 5
  - 5 held >=5 cycles until sensor 010 -> 3
  - second 111 then 010 -> 29; a new start edge -> 0
REQ-037 Obstacle mid-turn: obstacle=1 on cycle 2 of LEFT -> 30; clear after 20 cycles -> 5, exiting after 3 more timer cycles plus sensor[1]==1.
REQ-038 Lost line: sensor 000 for 8 cycles in STRAIGHT -> 31. A single 010 at cycle 7 resets the count, so no ERROR occurs.
REQ-039 Reset mid-operation: rst during BACK -> 0/0 next cycle. A subsequent start edge replays from plan entry 0.

Source files
------------

// File: rtl/car_mode_pkg.sv
// Shared drive-mode definitions for the line-following car.
// Used by drive_sequencer and the motor driver, so the numeric mode codes
// here are part of the external interface and must not be renumbered.
//   car_mode_e : 5-bit drive mode encoding
//   ACT_*      : two-bit junction actions stored in the route plan
//   max3       : helper for sizing counters from several parameters
package car_mode_pkg;

    typedef enum logic [4:0] {
        MODE_IDLE         = 5'd0,
        MODE_START        = 5'd1,
        MODE_COUNT        = 5'd2,
        MODE_STRAIGHT     = 5'd3,
        MODE_CHOOSE       = 5'd4,
        MODE_LEFT         = 5'd5,
        MODE_RIGHT        = 5'd6,
        MODE_BACK         = 5'd7,
        MODE_LITTLE_LEFT  = 5'd8,
        MODE_LITTLE_RIGHT = 5'd9,
        MODE_FINISH       = 5'd29,
        MODE_STOP         = 5'd30,
        MODE_ERROR        = 5'd31
    } car_mode_e;

    localparam logic [1:0] ACT_STRAIGHT = 2'd0;
    localparam logic [1:0] ACT_LEFT     = 2'd1;
    localparam logic [1:0] ACT_RIGHT    = 2'd2;
    localparam logic [1:0] ACT_BACK     = 2'd3;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting cycle timer shared by the COUNT phase and the turn states.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load value_i (has priority over counting)
//   value_i    : number of further cycles to count after the load cycle
//   enable_i   : count down this cycle; low freezes the timer
//   expired_o  : high while the count is zero
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         enable_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturates at zero so a long wait for the line never wraps the count.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/drive_sequencer.sv
// Top-level drive sequencer: start-up countdown, line tracking, junction
// actions from a fixed route plan, obstacle pause and lost-line detection.
//   clk, rst   : 100 MHz clock, synchronous active-high reset
//   start      : start button (synchronized, debounced); rising edge acts
//   sensor     : line sensors {left,mid,right}, 1 = line seen
//   obstacle   : too-close flag (synchronized)
//   mode       : registered drive mode (car_mode_e code)
//   lastMode   : registered previous distinct mode
module drive_sequencer
    import car_mode_pkg::*;
#(
    parameter int unsigned COUNT_CYCLES = 100_000_000,
    parameter int unsigned TURN_CYCLES  = 30_000_000,
    parameter int unsigned BACK_CYCLES  = 60_000_000,
    parameter int unsigned LOST_CYCLES  = 50_000_000,
    parameter logic [31:0] PLAN         = 32'h0,
    parameter int unsigned PLAN_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] sensor,
    input  logic       obstacle,
    output logic [4:0] mode,
    output logic [4:0] lastMode
);

    localparam int TMR_W  = $clog2(max3(COUNT_CYCLES, TURN_CYCLES, BACK_CYCLES) + 1);
    localparam int LOST_W = $clog2(LOST_CYCLES + 1);

    // Timer reloads are one less than the dwell time: the entry cycle itself
    // counts as the first cycle spent in the timed state.
    localparam logic [TMR_W-1:0]  COUNT_LD  = TMR_W'(COUNT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TURN_LD   = TMR_W'(TURN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  BACK_LD   = TMR_W'(BACK_CYCLES - 1);
    localparam logic [LOST_W-1:0] LOST_MAX  = LOST_W'(LOST_CYCLES);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_CYCLES - 1);
    localparam logic [4:0]        PLAN_END  = 5'(PLAN_LEN);

    car_mode_e         state_q, state_d;
    car_mode_e         saved_q, saved_d;
    car_mode_e         last_q, last_d;
    logic [4:0]        idx_q, idx_d;
    logic [LOST_W-1:0] lost_q, lost_d;
    logic              start_prev_q;
    logic              start_rise;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_en;
    logic              tmr_exp;
    logic [1:0]        plan_act;

    assign start_rise = start & ~start_prev_q;
    assign plan_act   = PLAN[{idx_q[3:0], 1'b0} +: 2];
    // STOP is not in this list, which is what freezes a paused turn.
    assign tmr_en     = (state_q == MODE_COUNT) || (state_q == MODE_LEFT) ||
                        (state_q == MODE_RIGHT) || (state_q == MODE_BACK);

    cycle_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .value_i  (tmr_val),
        .enable_i (tmr_en),
        .expired_o(tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        idx_d    = idx_q;
        lost_d   = lost_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            MODE_IDLE: begin
                if (start_rise) state_d = MODE_START;
            end
            MODE_START: begin
                state_d  = MODE_COUNT;
                tmr_load = 1'b1;
                tmr_val  = COUNT_LD;
            end
            MODE_COUNT: begin
                if (tmr_exp) begin
                    state_d = MODE_STRAIGHT;
                    idx_d   = '0;
                    lost_d  = '0;
                end
            end
            MODE_STRAIGHT, MODE_LITTLE_LEFT, MODE_LITTLE_RIGHT: begin
                if (sensor == 3'b000) begin
                    lost_d = (lost_q == LOST_MAX) ? lost_q : lost_q + LOST_W'(1);
                end else begin
                    lost_d = '0;
                end
                case (sensor)
                    3'b010:         state_d = MODE_STRAIGHT;
                    3'b110, 3'b100: state_d = MODE_LITTLE_LEFT;
                    3'b011, 3'b001: state_d = MODE_LITTLE_RIGHT;
                    3'b111:         state_d = MODE_CHOOSE;
                    3'b000: begin
                        if (lost_q >= LOST_LAST) state_d = MODE_ERROR;
                    end
                    default: ;  // 101: ambiguous reading, keep steering as is
                endcase
            end
            MODE_CHOOSE: begin
                if (sensor != 3'b111) begin
                    idx_d = idx_q + 5'd1;
                    if (idx_q + 5'd1 == PLAN_END) begin
                        state_d = MODE_FINISH;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TURN_LD;
                        case (plan_act)
                            ACT_STRAIGHT: state_d = MODE_STRAIGHT;
                            ACT_LEFT:     state_d = MODE_LEFT;
                            ACT_RIGHT:    state_d = MODE_RIGHT;
                            default: begin
                                state_d = MODE_BACK;
                                tmr_val = BACK_LD;
                            end
                        endcase
                    end
                end
            end
            MODE_LEFT, MODE_RIGHT, MODE_BACK: begin
                if (tmr_exp && sensor[1]) state_d = MODE_STRAIGHT;
            end
            MODE_STOP: begin
                if (!obstacle) state_d = saved_q;
            end
            MODE_FINISH, MODE_ERROR: begin
                if (start_rise) state_d = MODE_IDLE;
            end
            default: state_d = MODE_IDLE;
        endcase

        // Obstacle overrides any transition chosen above; the junction is not
        // consumed and the turn timer is not reloaded.
        if (obstacle && ((state_q == MODE_STRAIGHT) || (state_q == MODE_CHOOSE) ||
                         (state_q == MODE_LITTLE_LEFT) || (state_q == MODE_LITTLE_RIGHT) ||
                         (state_q == MODE_LEFT) || (state_q == MODE_RIGHT) ||
                         (state_q == MODE_BACK))) begin
            state_d  = MODE_STOP;
            saved_d  = state_q;
            idx_d    = idx_q;
            tmr_load = 1'b0;
        end

        last_d = (state_d != state_q) ? state_q : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MODE_IDLE;
            saved_q      <= MODE_IDLE;
            last_q       <= MODE_IDLE;
            idx_q        <= '0;
            lost_q       <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            lost_q       <= lost_d;
            start_prev_q <= start;
        end
    end

    assign mode     = state_q;
    assign lastMode = last_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: two instances share stimulus, one with route
// {left,right} and one with route {back,right}, both checked each cycle
// against a behavioural model, plus directed scenarios with literal values.
module tb_drive_sequencer;

    localparam int CNT  = 10;
    localparam int TRN  = 5;
    localparam int BCK  = 7;
    localparam int LST  = 8;
    localparam int PLEN = 2;
    localparam logic [31:0] PLAN_A = 32'h9;  // entry0 left, entry1 right
    localparam logic [31:0] PLAN_B = 32'hB;  // entry0 back, entry1 right

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] sensor;
    logic       obstacle;
    logic [4:0] modeA, lastA, modeB, lastB;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        int mode;
        int last;
        int idx;
        int el;     // cycles already spent in the current timed state
        int lost;   // consecutive 000 readings while tracking
        int saved;
        bit pst;
    } ms_t;

    ms_t mA, mB;

    always #5 clk = ~clk;

    drive_sequencer #(
        .COUNT_CYCLES(CNT), .TURN_CYCLES(TRN), .BACK_CYCLES(BCK),
        .LOST_CYCLES(LST), .PLAN(PLAN_A), .PLAN_LEN(PLEN)
    ) dutA (
        .clk(clk), .rst(rst), .start(start), .sensor(sensor),
        .obstacle(obstacle), .mode(modeA), .lastMode(lastA)
    );

    drive_sequencer #(
        .COUNT_CYCLES(CNT), .TURN_CYCLES(TRN), .BACK_CYCLES(BCK),
        .LOST_CYCLES(LST), .PLAN(PLAN_B), .PLAN_LEN(PLEN)
    ) dutB (
        .clk(clk), .rst(rst), .start(start), .sensor(sensor),
        .obstacle(obstacle), .mode(modeB), .lastMode(lastB)
    );

    function automatic ms_t mstep(ms_t s, bit r, bit st, bit [2:0] sn, bit ob,
                                  bit [31:0] plan);
        ms_t n;
        int  nm;
        int  a;
        bit  rise;
        if (r) return '0;
        n      = s;
        rise   = st && !s.pst;
        n.pst  = st;
        nm     = s.mode;
        if (s.mode inside {2, 5, 6, 7}) n.el = s.el + 1;
        case (s.mode)
            0: if (rise) nm = 1;
            1: begin nm = 2; n.el = 0; end
            2: if (s.el + 1 >= CNT) begin nm = 3; n.idx = 0; n.lost = 0; end
            3, 8, 9: begin
                n.lost = (sn == 3'b000) ? ((s.lost < LST) ? s.lost + 1 : LST) : 0;
                case (sn)
                    3'b010:         nm = 3;
                    3'b110, 3'b100: nm = 8;
                    3'b011, 3'b001: nm = 9;
                    3'b111:         nm = 4;
                    3'b000:         if (s.lost + 1 >= LST) nm = 31;
                    default: ;
                endcase
            end
            4: if (sn != 3'b111) begin
                n.idx = s.idx + 1;
                if (n.idx == PLEN) nm = 29;
                else begin
                    a    = int'((plan >> (2 * s.idx)) & 32'd3);
                    nm   = (a == 0) ? 3 : (a == 1) ? 5 : (a == 2) ? 6 : 7;
                    n.el = 0;
                end
            end
            5, 6: if (s.el + 1 >= TRN && sn[1]) nm = 3;
            7:    if (s.el + 1 >= BCK && sn[1]) nm = 3;
            30:   if (!ob) nm = s.saved;
            29, 31: if (rise) nm = 0;
            default: ;
        endcase
        if (ob && (s.mode inside {3, 4, 5, 6, 7, 8, 9})) begin
            nm      = 30;
            n.saved = s.mode;
            n.idx   = s.idx;
        end
        n.last = (nm != s.mode) ? s.mode : s.last;
        n.mode = nm;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // One clock: advance the models with the inputs seen at the edge, then
    // compare both instances on the falling edge.
    task automatic tick();
        @(posedge clk);
        mA = mstep(mA, rst, start, sensor, obstacle, PLAN_A);
        mB = mstep(mB, rst, start, sensor, obstacle, PLAN_B);
        @(negedge clk);
        chk("model_modeA", {27'd0, modeA}, mA.mode);
        chk("model_lastA", {27'd0, lastA}, mA.last);
        chk("model_modeB", {27'd0, modeB}, mB.mode);
        chk("model_lastB", {27'd0, lastB}, mB.last);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // From IDLE with start low: START for one cycle, COUNT for ten, STRAIGHT.
    task automatic bringup();
        sensor = 3'b010;
        start  = 1'b1;
        tick();
        chk("bringup_start", {27'd0, modeA}, 1);
        start = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            tick();
            chk("bringup_count", {27'd0, modeA}, 2);
        end
        tick();
        chk("bringup_straight", {27'd0, modeA}, 3);
        chk("bringup_last", {27'd0, lastA}, 2);
    endtask

    int hold;
    int r;

    initial begin
        mA       = '0;
        mB       = '0;
        rst      = 1'b1;
        start    = 1'b0;
        sensor   = 3'b010;
        obstacle = 1'b0;
        ticks(2);
        chk("reset_mode", {27'd0, modeA}, 0);
        chk("reset_last", {27'd0, lastA}, 0);
        rst = 1'b0;
        tick();
        chk("idle_hold", {27'd0, modeA}, 0);

        bringup();

        // line following
        sensor = 3'b110; tick();
        chk("ll_mode", {27'd0, modeA}, 8);
        sensor = 3'b010; tick();
        chk("back_straight", {27'd0, modeA}, 3);
        chk("back_straight_last", {27'd0, lastA}, 8);
        sensor = 3'b011; tick();
        chk("lr_mode", {27'd0, modeA}, 9);
        sensor = 3'b010; tick();

        // junction 1: A turns left, B backs up
        sensor = 3'b111; ticks(3);
        chk("choose_mode", {27'd0, modeA}, 4);
        sensor = 3'b000; tick();
        chk("dispatch_left", {27'd0, modeA}, 5);
        chk("dispatch_back", {27'd0, modeB}, 7);
        ticks(4);
        chk("left_held", {27'd0, modeA}, 5);
        sensor = 3'b010; tick();
        chk("left_exit", {27'd0, modeA}, 3);
        chk("left_exit_last", {27'd0, lastA}, 5);
        chk("back_still", {27'd0, modeB}, 7);
        ticks(2);
        chk("back_exit", {27'd0, modeB}, 3);

        // junction 2 ends the route
        sensor = 3'b111; tick();
        sensor = 3'b010; tick();
        chk("finish_mode", {27'd0, modeA}, 29);
        chk("finish_last", {27'd0, lastA}, 4);
        obstacle = 1'b1; tick();
        chk("finish_ignores_obstacle", {27'd0, modeA}, 29);
        obstacle = 1'b0;
        start = 1'b1; tick();
        chk("finish_to_idle", {27'd0, modeA}, 0);
        start = 1'b0; tick();

        // obstacle on the second cycle of LEFT
        bringup();
        sensor = 3'b111; tick();
        sensor = 3'b000; tick();
        tick();
        obstacle = 1'b1; tick();
        chk("stop_mode", {27'd0, modeA}, 30);
        chk("stop_last", {27'd0, lastA}, 5);
        ticks(19);
        chk("stop_held", {27'd0, modeA}, 30);
        obstacle = 1'b0; sensor = 3'b010; tick();
        chk("stop_resume", {27'd0, modeA}, 5);
        ticks(2);
        chk("resume_left_held", {27'd0, modeA}, 5);
        tick();
        chk("resume_left_exit", {27'd0, modeA}, 3);
        ticks(2);

        // lost line: a single 010 restarts the count
        sensor = 3'b000; ticks(6);
        sensor = 3'b010; tick();
        sensor = 3'b000; ticks(7);
        chk("lost_not_yet", {27'd0, modeA}, 3);
        tick();
        chk("lost_error", {27'd0, modeA}, 31);
        chk("lost_error_last", {27'd0, lastA}, 3);
        start = 1'b1; tick();
        chk("error_to_idle", {27'd0, modeA}, 0);
        start = 1'b0; tick();

        // reset during BACK, then the route replays from entry 0
        bringup();
        sensor = 3'b111; tick();
        sensor = 3'b000; tick();
        ticks(2);
        chk("pre_reset_back", {27'd0, modeB}, 7);
        rst = 1'b1; tick();
        chk("midrst_mode", {27'd0, modeB}, 0);
        chk("midrst_last", {27'd0, lastB}, 0);
        rst = 1'b0; tick();
        bringup();
        sensor = 3'b111; tick();
        sensor = 3'b000; tick();
        chk("replay_back", {27'd0, modeB}, 7);
        chk("replay_left", {27'd0, modeA}, 5);

        // randomized traffic, checked only against the models
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 10);
                r    = $urandom_range(0, 99);
                if (r < 40)      sensor = 3'b010;
                else if (r < 55) sensor = 3'(($urandom_range(0, 3) == 0) ? 3'b110 :
                                               ($urandom_range(0, 2) == 0) ? 3'b100 :
                                               ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b001);
                else if (r < 65) sensor = 3'b111;
                else if (r < 68) sensor = 3'b101;
                else             sensor = 3'b000;
            end
            hold--;
            if ($urandom_range(0, 29) == 0) obstacle = ~obstacle;
            if ($urandom_range(0, 24) == 0) start = ~start;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
